// File: rtl/mux_stim_sequencer.sv
// -----------------------------------------------------------------------------
// mux_stim_sequencer
//   Stimulus source for the 2:1 mux lab stage. It walks the mux data pair and
//   select through a fixed 8-step sequence:
//     (in,sel): (0,0) -> (1,0) (2,0) (3,1) (0,1) (1,1) (2,1) (3,0) (0,0) ...
//   The step rate is set by a prescaler while running. The block can also be
//   paused, single-stepped, and stopped after a fixed number of sweeps.
//
// Parameters
//   DIV     clk cycles per automatic step while running (1..65535)
//   SWEEPS  full sweeps before DONE (0..255, 0 = run forever)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-high reset
//   start      in   level request to begin (IDLE/DONE) or resume (PAUSE)
//   stop       in   level request to pause; wins over start everywhere
//   step       in   single advance request, honoured only in PAUSE
//   in[1:0]    out  mux data inputs (registered)
//   sel        out  mux select (registered)
//   valid      out  one-cycle pulse marking a fresh in/sel vector
//   sweep_cnt  out  completed sweeps (wraps 255 -> 0)
//   busy       out  high in RUN or PAUSE
//   done       out  high in DONE
//   state_dbg  out  current FSM state, for debug and checkers
//
// Handshake: valid is a push-only strobe with no ready. It is high for exactly
// the first cycle in which a new in/sel/sweep_cnt value is present; consumers
// must sample on that cycle and cannot apply backpressure.
// -----------------------------------------------------------------------------
module mux_stim_sequencer #(
  parameter int unsigned DIV    = 4,
  parameter int unsigned SWEEPS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       step,
  output logic [1:0] in,
  output logic       sel,
  output logic       valid,
  output logic [7:0] sweep_cnt,
  output logic       busy,
  output logic       done,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [15:0] DIV_LAST    = 16'(DIV - 1);
  localparam logic [7:0]  SWEEPS_LIM  = 8'(SWEEPS);
  localparam bit          RUN_FOREVER = (SWEEPS == 0);

  state_e      state_q;
  logic [1:0]  in_q;
  logic        sel_q;
  logic [7:0]  cnt_q;
  logic [15:0] presc_q;
  logic        valid_q;
  logic        busy_q;
  logic        done_q;

  // Values the sequence moves to on the next advance.
  logic [1:0]  in_d;
  logic        sel_d;
  logic        wrap_d;
  logic [7:0]  cnt_d;
  logic        finish_d;

  // Advance requests from the two sources that can move the sequence.
  logic        run_go;
  logic        resume_go;
  logic        adv_run;
  logic        adv_step;
  logic        adv;

  always_comb begin
    in_d     = in_q + 2'd1;
    // sel flips whenever the data pair lands on 3.
    sel_d    = sel_q ^ (in_d == 2'd3);
    // Landing back on (0,0) closes a sweep.
    wrap_d   = (in_d == 2'd0) && !sel_d;
    cnt_d    = cnt_q + {7'd0, wrap_d};
    finish_d = wrap_d && !RUN_FOREVER && (cnt_d == SWEEPS_LIM);
  end

  always_comb begin
    run_go    = start && !stop;
    resume_go = (state_q == S_PAUSE) && run_go;
    // stop blocks the advance even when the prescaler is at its last count.
    adv_run   = (state_q == S_RUN) && !stop && (presc_q == DIV_LAST);
    adv_step  = (state_q == S_PAUSE) && step && !start && !stop;
    adv       = adv_run || adv_step;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      in_q    <= 2'd0;
      sel_q   <= 1'b0;
      cnt_q   <= 8'd0;
      presc_q <= 16'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= adv;

      if (adv) begin
        in_q  <= in_d;
        sel_q <= sel_d;
        cnt_q <= cnt_d;
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (run_go) begin
            // Fresh run: nothing from a previous run is carried over.
            state_q <= S_RUN;
            in_q    <= 2'd0;
            sel_q   <= 1'b0;
            cnt_q   <= 8'd0;
            presc_q <= 16'd0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end

        S_RUN: begin
          if (stop) begin
            state_q <= S_PAUSE;
          end else if (adv_run) begin
            presc_q <= 16'd0;
            if (finish_d) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            presc_q <= presc_q + 16'd1;
          end
        end

        S_PAUSE: begin
          if (resume_go) begin
            // Resume keeps in/sel but restarts the step interval.
            state_q <= S_RUN;
            presc_q <= 16'd0;
          end else if (adv_step && finish_d) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in        = in_q;
  assign sel       = sel_q;
  assign valid     = valid_q;
  assign sweep_cnt = cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mux_stim_sequencer.sv
module tb_mux_stim_sequencer;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // DUT A: DIV=4, SWEEPS=2
  logic       start_a, stop_a, step_a;
  logic [1:0] in_a;
  logic       sel_a, valid_a, busy_a, done_a;
  logic [7:0] cnt_a;
  logic [1:0] st_a;

  // DUT B: DIV=1, SWEEPS=0 (free running)
  logic       start_b, stop_b, step_b;
  logic [1:0] in_b;
  logic       sel_b, valid_b, busy_b, done_b;
  logic [7:0] cnt_b;
  logic [1:0] st_b;

  mux_stim_sequencer #(.DIV(4), .SWEEPS(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stop(stop_a), .step(step_a),
    .in(in_a), .sel(sel_a), .valid(valid_a), .sweep_cnt(cnt_a),
    .busy(busy_a), .done(done_a), .state_dbg(st_a)
  );

  mux_stim_sequencer #(.DIV(1), .SWEEPS(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .step(step_b),
    .in(in_b), .sel(sel_b), .valid(valid_b), .sweep_cnt(cnt_b),
    .busy(busy_b), .done(done_b), .state_dbg(st_b)
  );

  // ---------------------------------------------------------------------------
  // Reference sequence and scoreboard
  // ---------------------------------------------------------------------------
  logic [1:0] seq_in  [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic       seq_sel [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  int         checks   = 0;
  int         failures = 0;
  int         seq_idx  = 0;
  logic [7:0] exp_cnt  = 8'd0;
  logic [10:0] exp_q[$];
  logic [10:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic restart_model();
    seq_idx = 0;
    exp_cnt = 8'd0;
  endtask

  // Expected vector for the next advance: {in, sel, sweep_cnt}.
  task automatic push_next();
    if (seq_idx == 7) exp_cnt = exp_cnt + 8'd1;
    exp_q.push_back({seq_in[seq_idx], seq_sel[seq_idx], exp_cnt});
    seq_idx = (seq_idx + 1) % 8;
  endtask

  always @(negedge clk) begin
    if (!rst && valid_a) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual in=%0d sel=%0d cnt=%0d required no valid at %0t",
                 in_a, sel_a, cnt_a, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_vector", {21'd0, in_a, sel_a, cnt_a}, {21'd0, mon_e});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  // n edges until the next automatic advance; all earlier edges must be quiet.
  task automatic expect_adv(input int n, input string tag);
    for (int i = 1; i < n; i++) begin
      tick();
      check({tag, "_quiet"}, {31'd0, valid_a}, 32'd0);
    end
    push_next();
    tick();
    check({tag, "_valid"}, {31'd0, valid_a}, 32'd1);
  endtask

  typedef struct {
    logic       start;
    logic       stop;
    logic       step;
    logic [1:0] exp_state;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[12];

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin : main
    int nvalid;

    vecs[0]  = '{1'b1, 1'b1, 1'b0, ST_IDLE,  1'b0, 1'b0, 1'b0}; // start&stop in IDLE
    vecs[1]  = '{1'b0, 1'b0, 1'b1, ST_IDLE,  1'b0, 1'b0, 1'b0}; // step ignored in IDLE
    vecs[2]  = '{1'b0, 1'b0, 1'b0, ST_IDLE,  1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, ST_RUN,   1'b1, 1'b0, 1'b0}; // start
    vecs[4]  = '{1'b1, 1'b1, 1'b0, ST_PAUSE, 1'b1, 1'b0, 1'b0}; // start&stop in RUN
    vecs[5]  = '{1'b0, 1'b0, 1'b1, ST_PAUSE, 1'b1, 1'b0, 1'b1}; // step -> (1,0)
    vecs[6]  = '{1'b0, 1'b1, 1'b1, ST_PAUSE, 1'b1, 1'b0, 1'b0}; // stop blocks step
    vecs[7]  = '{1'b1, 1'b0, 1'b1, ST_RUN,   1'b1, 1'b0, 1'b0}; // start wins over step
    vecs[8]  = '{1'b0, 1'b0, 1'b0, ST_RUN,   1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, ST_PAUSE, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, ST_PAUSE, 1'b1, 1'b0, 1'b1}; // step -> (2,0)
    vecs[11] = '{1'b1, 1'b1, 1'b1, ST_PAUSE, 1'b1, 1'b0, 1'b0}; // all three: hold

    rst = 1'b1;
    start_a = 1'b0; stop_a = 1'b0; step_a = 1'b0;
    start_b = 1'b0; stop_b = 1'b0; step_b = 1'b0;

    // Reset values before any clock edge.
    #3;
    check("rst_in",    {30'd0, in_a},  32'd0);
    check("rst_sel",   {31'd0, sel_a}, 32'd0);
    check("rst_cnt",   {24'd0, cnt_a}, 32'd0);
    check("rst_valid", {31'd0, valid_a}, 32'd0);
    check("rst_busy",  {31'd0, busy_a}, 32'd0);
    check("rst_done",  {31'd0, done_a}, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rst_state", {30'd0, st_a}, {30'd0, ST_IDLE});

    // Run two full sweeps at DIV=4.
    restart_model();
    pulse_start_a();
    check("start_busy", {31'd0, busy_a}, 32'd1);
    check("start_state", {30'd0, st_a}, {30'd0, ST_RUN});
    for (int k = 0; k < 16; k++) begin
      expect_adv(4, "run");
      if (k == 7) check("sweep1_cnt", {24'd0, cnt_a}, 32'd1);
    end
    check("done_flag",  {31'd0, done_a}, 32'd1);
    check("done_busy",  {31'd0, busy_a}, 32'd0);
    check("done_state", {30'd0, st_a}, {30'd0, ST_DONE});
    check("done_in",    {30'd0, in_a}, 32'd0);
    check("done_sel",   {31'd0, sel_a}, 32'd0);
    check("done_cnt",   {24'd0, cnt_a}, 32'd2);

    nvalid = 0;
    repeat (50) begin
      tick();
      if (valid_a) nvalid++;
    end
    check("done_no_valid", nvalid, 32'd0);
    check("done_hold", {31'd0, done_a}, 32'd1);

    // Restart from DONE.
    restart_model();
    pulse_start_a();
    check("restart_cnt",  {24'd0, cnt_a}, 32'd0);
    check("restart_done", {31'd0, done_a}, 32'd0);
    check("restart_busy", {31'd0, busy_a}, 32'd1);
    expect_adv(4, "restart");

    // Pause, hold, single step, resume.
    expect_adv(4, "pre_pause");
    expect_adv(4, "pre_pause");
    stop_a = 1'b1;
    tick();
    stop_a = 1'b0;
    check("pause_state", {30'd0, st_a}, {30'd0, ST_PAUSE});
    check("pause_busy",  {31'd0, busy_a}, 32'd1);
    check("pause_valid", {31'd0, valid_a}, 32'd0);
    repeat (20) begin
      tick();
      check("pause_hold_valid", {31'd0, valid_a}, 32'd0);
      check("pause_hold_in",    {30'd0, in_a}, 32'd3);
      check("pause_hold_sel",   {31'd0, sel_a}, 32'd1);
    end
    step_a = 1'b1;
    push_next();
    tick();
    step_a = 1'b0;
    check("step_valid", {31'd0, valid_a}, 32'd1);
    check("step_in",    {30'd0, in_a}, 32'd0);
    check("step_sel",   {31'd0, sel_a}, 32'd1);
    pulse_start_a();
    check("resume_state", {30'd0, st_a}, {30'd0, ST_RUN});
    check("resume_valid", {31'd0, valid_a}, 32'd0);
    expect_adv(4, "resume");

    // Held step: one advance per cycle, crossing a sweep boundary.
    stop_a = 1'b1;
    tick();
    stop_a = 1'b0;
    step_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_next();
      tick();
      check("held_step_valid", {31'd0, valid_a}, 32'd1);
    end
    step_a = 1'b0;
    tick();
    check("held_step_release", {31'd0, valid_a}, 32'd0);
    check("held_step_cnt", {24'd0, cnt_a}, 32'd1);
    check("held_step_state", {30'd0, st_a}, {30'd0, ST_PAUSE});

    // Asynchronous reset mid-run.
    pulse_start_a();
    expect_adv(4, "pre_reset");
    repeat (2) tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_in",    {30'd0, in_a}, 32'd0);
    check("arst_sel",   {31'd0, sel_a}, 32'd0);
    check("arst_cnt",   {24'd0, cnt_a}, 32'd0);
    check("arst_valid", {31'd0, valid_a}, 32'd0);
    check("arst_busy",  {31'd0, busy_a}, 32'd0);
    check("arst_done",  {31'd0, done_a}, 32'd0);
    exp_q.delete();
    restart_model();
    tick();
    rst = 1'b0;
    tick();
    check("arst_state", {30'd0, st_a}, {30'd0, ST_IDLE});

    // Table-driven control priority vectors.
    for (int v = 0; v < 12; v++) begin
      start_a = vecs[v].start;
      stop_a  = vecs[v].stop;
      step_a  = vecs[v].step;
      if (vecs[v].exp_valid) push_next();
      tick();
      check($sformatf("vec%0d_state", v), {30'd0, st_a}, {30'd0, vecs[v].exp_state});
      check($sformatf("vec%0d_busy", v),  {31'd0, busy_a}, {31'd0, vecs[v].exp_busy});
      check($sformatf("vec%0d_done", v),  {31'd0, done_a}, {31'd0, vecs[v].exp_done});
      check($sformatf("vec%0d_valid", v), {31'd0, valid_a}, {31'd0, vecs[v].exp_valid});
    end
    start_a = 1'b0; stop_a = 1'b0; step_a = 1'b0;
    check("vec_end_in", {30'd0, in_a}, 32'd2);

    // Free-running DIV=1, SWEEPS=0: advance every cycle, counter wraps.
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("b_busy", {31'd0, busy_b}, 32'd1);
    for (int k = 1; k <= 2100; k++) begin
      tick();
      check("b_valid", {31'd0, valid_b}, 32'd1);
      check("b_in",    {30'd0, in_b},  {30'd0, seq_in[(k - 1) % 8]});
      check("b_sel",   {31'd0, sel_b}, {31'd0, seq_sel[(k - 1) % 8]});
      check("b_cnt",   {24'd0, cnt_b}, (k / 8) % 256);
      if (k == 2047) check("b_cnt_pre_wrap", {24'd0, cnt_b}, 32'd255);
      if (k == 2048) check("b_cnt_wrap", {24'd0, cnt_b}, 32'd0);
    end
    check("b_done", {31'd0, done_b}, 32'd0);
    check("b_state", {30'd0, st_b}, {30'd0, ST_RUN});

    tick();
    check("sb_drain", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_stim_sequencer.md
Name: mux_stim_sequencer

Overview:
Upstream stimulus source for the 2:1 mux lab stage. It drives the mux data pair `in[1:0]` and the select `sel` through a fixed 8-step sequence at a programmable step rate. Run, pause, single-step and sweep-limit control come from board buttons or a bench. The `valid` pulse marks each new vector, so a downstream checker or display samples `in`, `sel` and the mux `out` exactly once per step.

Parameters:
- DIV, 4: clk cycles per automatic step while running; legal range 1..65535.
- SWEEPS, 2: number of full 8-step sweeps before DONE; legal range 0..255; 0 = run forever.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: level-sampled request to begin or resume running.
- stop, input, 1: level-sampled request to pause.
- step, input, 1: single-step request; acted on only in PAUSE.
- in, output, 2: mux data inputs; registered.
- sel, output, 1: mux select; registered.
- valid, output, 1: one-cycle pulse, high in the first cycle each new in/sel value is present.
- sweep_cnt, output, 8: number of completed sweeps.
- busy, output, 1: high in RUN or PAUSE.
- done, output, 1: high in DONE.

Behaviour:
- Reset (async, rst=1): state=IDLE, in=0, sel=0, sweep_cnt=0, valid=0, busy=0, done=0, prescaler=0. Outputs clear with no clock edge required.
- Update rule, applied once per "advance":
  - in_next = in+1 (mod 4).
  - If in_next==3, sel toggles.
  - Sequence from (in,sel)=(0,0): (1,0) (2,0) (3,1) (0,1) (1,1) (2,1) (3,0) (0,0).
  - A sweep completes on the advance that lands on (0,0); that advance increments sweep_cnt (8-bit, wraps 255->0).
- States: IDLE, RUN, PAUSE, DONE. `stop` has priority over `start` in every state.
- IDLE:
  - start & !stop -> RUN. Clears in, sel, sweep_cnt and prescaler.
  - step is ignored.
- RUN:
  - Prescaler counts 0..DIV-1; an advance occurs on the edge where the count equals DIV-1, then the count wraps to 0.
  - The first advance occurs DIV edges after the edge that accepted start.
  - DIV=1 gives an advance every cycle.
  - stop -> PAUSE; no advance on that edge, even if the prescaler is at DIV-1.
  - If an advance completes a sweep and SWEEPS!=0 and the new sweep_cnt==SWEEPS -> DONE. The in/sel values (0,0) are still presented with valid=1.
- PAUSE:
  - in, sel and sweep_cnt hold.
  - step & !start & !stop: exactly one advance on that edge, with a valid pulse. Sweep completion rules apply, so PAUSE can go to DONE.
  - A held step produces one advance per cycle; no edge detection is done in this block.
  - start & !stop -> RUN, resuming from the current in/sel. The prescaler clears to 0, so the next advance is DIV edges later.
- DONE:
  - Outputs hold (in=0, sel=0, sweep_cnt=SWEEPS), done=1, no valid pulses.
  - start & !stop -> RUN with a full clear, as from IDLE.
- valid is registered alongside in/sel and is 0 on every edge without an advance.
- Asserting rst mid-run returns the block to IDLE with the reset values above. No partial sweep is retained.

Test Plan:
1. Reset: assert rst asynchronously between clock edges mid-run -> in=0, sel=0, sweep_cnt=0, valid=0, busy=0, done=0 immediately; state is IDLE after release.
2. DIV=4, SWEEPS=2, single-cycle start pulse -> busy=1 next cycle. The first valid comes 4 edges after start with (1,0), then every 4 cycles: (2,0) (3,1) (0,1) (1,1) (2,1) (3,0) (0,0), and sweep_cnt=1 on the 8th.
3. Continue scenario 2 -> on the 16th advance in=0, sel=0, sweep_cnt=2, done=1, busy=0. No further valid over 50 cycles. A start pulse restarts the sequence from (1,0) with sweep_cnt=0.
4. Pause and step:
   - After 3 advances (3,1), assert stop for 1 cycle -> outputs hold for 20 cycles with valid=0.
   - Pulse step -> next edge gives (0,1) with valid=1.
   - Pulse start -> next advance to (1,1) occurs exactly 4 edges later.
5. Priority and ignored inputs:
   - In RUN, assert start&stop together -> PAUSE.
   - In IDLE, assert start&stop together -> stays IDLE.
   - In IDLE, pulse step -> no change.
6. SWEEPS=0, DIV=1, run 2100 cycles -> valid every cycle. sweep_cnt wraps 255->0 at advance 2048 and done stays 0.
